clk_div_tick_gen: RTL and testbench

Programmable single-clock divider that sits directly downstream of the system clock source and drives the power-of-two divider chain and other slow-domain logic. Produces a one-cycle clock-enable `tick` and a registered square wave `clk_out` at `clk / R`, with R run-time programmable from 1 to 2^CNT_W. Divisor changes use a req/ack handshake and take effect only on a period boundary, so `clk_out` never glitches or produces a runt.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_tick_gen_if.sv | 34 +++
 rtl/clk_div_cnt.sv | 40 ++++
 rtl/clk_div_tick_gen.sv | 124 ++++++++++++
 tb/tb_clk_div_tick_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } clk_div_state_t;

endpackage

// File: rtl/clk_div_tick_gen_if.sv
// Control/status bundle of the clock divider; CLK_DIV_SYNC_EN adds the sync_in phase-restart input.
interface clk_div_tick_gen_if #(
  parameter int CNT_W = clk_div_pkg::CLK_DIV_CNT_W_DEF
);
  import clk_div_pkg::*;

  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load_req;
  logic             div_load_ack;
  logic             busy;
  logic             tick;
  logic             clk_out;
`ifdef CLK_DIV_SYNC_EN
  logic             sync_in;
`endif

  modport master (
`ifdef CLK_DIV_SYNC_EN
    output sync_in,
`endif
    output en, div_val, div_load_req,
    input  div_load_ack, busy, tick, clk_out
  );

  modport slave (
`ifdef CLK_DIV_SYNC_EN
    input  sync_in,
`endif
    input  en, div_val, div_load_req,
    output div_load_ack, busy, tick, clk_out
  );

endinterface

// File: rtl/clk_div_cnt.sv
// Loadable down-counter with terminal-count flag; tick and clk_out are registered from the next count.
module clk_div_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] div_next,
  input  logic             run_next,
  output logic             tc,
  output logic             tick_reg,
  output logic             clk_out_reg
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   half_next;

  always_comb begin
    cnt_next  = load ? load_val : (cnt_reg - CNT_W'(1));
    // floor(R/2) for the divisor that governs the coming cycle
    half_next = ({1'b0, div_next} + (CNT_W+1)'(1)) >> 1;
  end

  assign tc = (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= CNT_W'(1);
      tick_reg    <= 1'b0;
      clk_out_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      tick_reg    <= run_next && (cnt_next == '0);
      clk_out_reg <= run_next && ({1'b0, cnt_next} >= half_next);
    end
  end

endmodule

// File: rtl/clk_div_tick_gen.sv
// Programmable clock divider: tick/clk_out at clk/R with glitch-free req/ack divisor reload.
// Optional macro CLK_DIV_SYNC_EN adds sync_in, which restarts the period phase.
module clk_div_tick_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CLK_DIV_CNT_W_DEF
) (
  input logic               clk,
  input logic               reset,
  clk_div_tick_gen_if.slave bus
);

  clk_div_state_t   state_reg, state_next;
  logic [CNT_W-1:0] div_act_reg, div_act_next;
  logic [CNT_W-1:0] div_shd_reg, div_shd_next;
  logic [CNT_W-1:0] cnt_load_val;
  logic             busy_reg, busy_next;
  logic             ack_reg, ack_next;
  logic             cnt_load;
  logic             run_next;
  logic             tc;
  logic             sync_run;
  logic             brk;
  logic             tick_q;
  logic             clk_out_q;

`ifdef CLK_DIV_SYNC_EN
  assign sync_run = bus.sync_in && (state_reg != STOP);
`else
  assign sync_run = 1'b0;
`endif

  // A period ends at terminal count or when a sync restarts the phase.
  assign brk      = tc || sync_run;
  assign run_next = (state_next != STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= STOP;
      div_act_reg <= CNT_W'(1);
      div_shd_reg <= CNT_W'(1);
      busy_reg    <= 1'b0;
      ack_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_act_reg <= div_act_next;
      div_shd_reg <= div_shd_next;
      busy_reg    <= busy_next;
      ack_reg     <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!bus.en) begin
      state_next = STOP;
    end else begin
      case (state_reg)
        STOP:    state_next = RUN;
        RUN:     if (bus.div_load_req) state_next = PEND;
        PEND:    if (!bus.div_load_req && brk) state_next = RUN;
        default: state_next = STOP;
      endcase
    end
  end

  always_comb begin
    div_act_next = div_act_reg;
    div_shd_next = bus.div_load_req ? bus.div_val : div_shd_reg;
    busy_next    = busy_reg;
    ack_next     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = div_act_reg;
    if (!bus.en || (state_reg == STOP)) begin
      // Parked or parking: counter rests at R-1 and any new divisor lands at once.
      cnt_load  = 1'b1;
      busy_next = 1'b0;
      if (bus.div_load_req) begin
        div_act_next = bus.div_val;
        ack_next     = 1'b1;
      end else if (state_reg == PEND) begin
        div_act_next = div_shd_reg;
        ack_next     = 1'b1;
      end
      cnt_load_val = div_act_next;
    end else if (bus.div_load_req) begin
      // A request on a boundary is held back so the next period keeps the old length.
      busy_next = 1'b1;
      cnt_load  = brk;
    end else if ((state_reg == PEND) && brk) begin
      div_act_next = div_shd_reg;
      busy_next    = 1'b0;
      ack_next     = 1'b1;
      cnt_load     = 1'b1;
      cnt_load_val = div_shd_reg;
    end else begin
      cnt_load = brk;
    end
  end

  clk_div_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .div_next   (div_act_next),
    .run_next   (run_next),
    .tc         (tc),
    .tick_reg   (tick_q),
    .clk_out_reg(clk_out_q)
  );

`ifdef CLK_DIV_SYNC_EN
  assign bus.tick = tick_q & ~bus.sync_in;
`else
  assign bus.tick = tick_q;
`endif
  assign bus.clk_out      = clk_out_q;
  assign bus.busy         = busy_reg;
  assign bus.div_load_ack = ack_reg;

endmodule

// File: tb/tb_clk_div_tick_gen.sv
// Scoreboard bench for clk_div_tick_gen: a period-position model predicts every output cycle.
module tb_clk_div_tick_gen;
  import clk_div_pkg::*;

  localparam int CNT_W = CLK_DIV_CNT_W_DEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clk_div_tick_gen_if #(.CNT_W(CNT_W)) bus ();

  clk_div_tick_gen #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int   cyc;
    logic tick;
    logic clk_out;
    logic ack;
    logic busy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Model: active period length R, position within the period (0 = first cycle).
  int m_r, m_shd, m_pos;
  bit m_run, m_pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      mon_e = sb_q.pop_front();
`ifdef CLK_DIV_SYNC_EN
      mon_e.tick = mon_e.tick & ~bus.sync_in;
`endif
      check("tick",    32'(bus.tick),         32'(mon_e.tick));
      check("clk_out", 32'(bus.clk_out),      32'(mon_e.clk_out));
      check("ack",     32'(bus.div_load_ack), 32'(mon_e.ack));
      check("busy",    32'(bus.busy),         32'(mon_e.busy));
    end
  end

  task automatic drv(input bit rst, input bit en_i, input bit req, input int val, input bit sync);
    exp_t e;
    bit   last, brk, ack;
    @(posedge clk);
    #1;
    reset            = rst;
    bus.en           = en_i;
    bus.div_load_req = req;
    bus.div_val      = CNT_W'(val);
`ifdef CLK_DIV_SYNC_EN
    bus.sync_in      = sync;
`endif
    ack = 1'b0;
    if (rst) begin
      m_run = 0; m_pend = 0; m_r = 2; m_shd = 2; m_pos = 0;
    end else if (!en_i) begin
      if (req) begin
        m_r = val + 1; ack = 1'b1;
      end else if (m_pend) begin
        m_r = m_shd; ack = 1'b1;
      end
      m_pend = 0; m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      if (req) begin
        m_r = val + 1; ack = 1'b1;
      end
      m_run = 1; m_pos = 0;
    end else begin
      last = (m_pos == m_r - 1);
      brk  = last || sync;
      if (req) begin
        m_shd = val + 1; m_pend = 1;
        m_pos = brk ? 0 : m_pos + 1;
      end else if (m_pend && brk) begin
        m_r = m_shd; m_pend = 0; ack = 1'b1; m_pos = 0;
      end else begin
        m_pos = brk ? 0 : m_pos + 1;
      end
    end
    e.cyc     = cyc + 1;
    e.tick    = m_run && (m_pos == m_r - 1);
    e.clk_out = m_run && (m_pos < (m_r + 1) / 2);
    e.ack     = ack;
    e.busy    = m_pend && !rst;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit en_i);
    for (int i = 0; i < n; i++) drv(0, en_i, 0, 0, 0);
  endtask

  task automatic load(input int v, input bit en_i);
    $display("req div_val=%0d en=%0d at cycle %0d", v, en_i, cyc);
    drv(0, en_i, 1, v, 0);
  endtask

  task automatic wait_pos(input int p, input int limit);
    int n = 0;
    while (!(m_run && m_pos == p) && n < limit) begin
      drv(0, 1, 0, 0, 0);
      n++;
    end
    check("wait_pos", 32'(m_run && m_pos == p), 32'd1);
  endtask

  initial begin
    bit e_r, q_r, s_r;
    int v_r;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.div_load_req = 1'b0;
    bus.div_val = '0;
`ifdef CLK_DIV_SYNC_EN
    bus.sync_in = 1'b0;
`endif
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    idle(2, 0);
    idle(8, 1);                          // default R = 2
    wait_pos(0, 8);  load(4, 1); idle(14, 1);   // to R = 5 mid-period
    load(2, 1);      idle(12, 1);               // to R = 3
    wait_pos(2, 8);  load(0, 1); idle(8, 1);    // req on terminal count, to R = 1
    load(4, 1);      idle(8, 1);
    wait_pos(1, 8);  load(7, 1); load(2, 1); idle(10, 1);  // two reqs, one ack
    wait_pos(1, 8);  drv(0, 0, 0, 0, 0); idle(3, 0); idle(8, 1);  // en drop mid-period
    wait_pos(0, 8);  load(5, 1); drv(1, 1, 0, 0, 0); idle(8, 1);  // reset while pending
    idle(2, 0);      load(3, 0); idle(2, 0); idle(10, 1);         // load while stopped
    load(1, 1);      drv(0, 0, 0, 0, 0); idle(2, 0); idle(6, 1);  // en drop while pending
    load(255, 1);    idle(600, 1);                                // maximum divisor
`ifdef CLK_DIV_SYNC_EN
    load(3, 1);      idle(8, 1);
    wait_pos(3, 8);  drv(0, 1, 0, 0, 1); idle(8, 1);              // sync at terminal count
    load(6, 1);      idle(1, 1); drv(0, 1, 0, 0, 1); idle(10, 1); // sync applies pending load
`endif
    for (int i = 0; i < 300; i++) begin
      e_r = ($urandom_range(0, 24) != 0);
      q_r = ($urandom_range(0, 11) == 0);
      v_r = $urandom_range(0, 15);
`ifdef CLK_DIV_SYNC_EN
      s_r = ($urandom_range(0, 19) == 0);
`else
      s_r = 1'b0;
`endif
      if (q_r) $display("req div_val=%0d en=%0d at cycle %0d", v_r, e_r, cyc);
      drv(0, e_r, q_r, v_r, s_r);
    end
    idle(3, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
